// File: rtl/stage_memory_pkg.sv
// Shared types for the MEM pipeline stage: result-source encodings and the bus FSM state.
package stage_memory_pkg;

    localparam logic [1:0] RESULT_SRC_ALU  = 2'b00;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4  = 2'b10;
    localparam logic [1:0] RESULT_SRC_IMM  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } mem_state_t;

    // Loads and stores are the only instructions that touch the data bus.
    function automatic logic is_access(input logic mem_write, input logic [1:0] result_src);
        return mem_write | (result_src == RESULT_SRC_LOAD);
    endfunction

endpackage

// File: rtl/stage_memory_if.sv
// Registered req/ack data-memory bus between the MEM stage (master) and data memory (slave).
interface stage_memory_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ack;

    modport master (output req, output we, output addr, output wdata, input rdata, input ack);
    modport slave  (input req, input we, input addr, input wdata, output rdata, output ack);
endinterface

// File: rtl/stage_memory_mem_bus_ctrl.sv
// Data-bus FSM for the MEM stage: request registers, load data capture and optional timeout.
// Timeout abort is built only when MEM_BUS_TIMEOUT_EN is defined.
module mem_bus_ctrl
    import stage_memory_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  access,
    input  logic                  mem_write,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [31:0]           wdata,
    stage_memory_if.master        bus,
    output mem_state_t            state,
    output logic [31:0]           rdata_q,
    output logic                  bus_error
);

    mem_state_t        state_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              tmo_hit;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] tmo_cnt_q;
    logic            err_q;

    assign tmo_hit = (state_q == StBusy) && (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == StIdle && access) begin
                tmo_cnt_q <= '0;
            end else if (state_q == StBusy) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            // An ack in the same cycle as the limit counts as a normal completion.
            if (tmo_hit && !bus.ack) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus_error = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
    assign bus_error      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (access) begin
                        req_q   <= 1'b1;
                        we_q    <= mem_write;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (bus.ack) begin
                        req_q <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= bus.rdata;
                        end
                        state_q <= StResp;
                    end else if (tmo_hit) begin
                        req_q   <= 1'b0;
                        rdata_q <= '0;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req   = req_q;
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign state     = state_q;

endmodule

// File: rtl/stage_memory.sv
// MEM pipeline stage: drives loads/stores onto the data bus, stalls the front end while an
// access is outstanding and owns the MEM/WB register. Optional MEM_BUS_TIMEOUT_EN bus timeout.
module stage_memory
    import stage_memory_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_clear,
    input  logic               mem_reg_write,
    input  logic               mem_mem_write,
    input  logic [1:0]         mem_result_src,
    input  logic [31:0]        mem_alu_result,
    input  logic [31:0]        mem_write_data,
    input  logic [31:0]        mem_pc_plus_4,
    input  logic [31:0]        mem_imm_ext,
    input  logic [4:0]         mem_rd,
    stage_memory_if.master     dmem,
    output logic               mem_stall,
    output logic               bus_error,
    output logic               wb_reg_write,
    output logic [1:0]         wb_result_src,
    output logic [31:0]        wb_alu_result,
    output logic [31:0]        wb_read_data,
    output logic [31:0]        wb_pc_plus_4,
    output logic [31:0]        wb_imm_ext,
    output logic [4:0]         wb_rd
);

    logic        access;
    mem_state_t  bus_state;
    logic [31:0] rdata_q;

    assign access = is_access(mem_mem_write, mem_result_src);

    mem_bus_ctrl #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_bus_ctrl (
        .clk       (clk),
        .rst       (rst),
        .access    (access),
        .mem_write (mem_mem_write),
        .addr      (mem_alu_result[ADDR_W-1:0]),
        .wdata     (mem_write_data),
        .bus       (dmem),
        .state     (bus_state),
        .rdata_q   (rdata_q),
        .bus_error (bus_error)
    );

    // RESP releases the stall so the access itself retires into MEM/WB that cycle.
    assign mem_stall = ((bus_state == StIdle) && access) || (bus_state == StBusy);

    always_ff @(posedge clk) begin
        if (rst || mem_stall || wb_clear) begin
            wb_reg_write  <= 1'b0;
            wb_result_src <= '0;
            wb_alu_result <= '0;
            wb_read_data  <= '0;
            wb_pc_plus_4  <= '0;
            wb_imm_ext    <= '0;
            wb_rd         <= '0;
        end else begin
            wb_reg_write  <= mem_reg_write;
            wb_result_src <= mem_result_src;
            wb_alu_result <= mem_alu_result;
            wb_read_data  <= (mem_result_src == RESULT_SRC_LOAD) ? rdata_q : 32'h0;
            wb_pc_plus_4  <= mem_pc_plus_4;
            wb_imm_ext    <= mem_imm_ext;
            wb_rd         <= mem_rd;
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Scoreboard bench for stage_memory: stimulus pushes expected MEM/WB records, a monitor checks
// every retired register write. Define MEM_BUS_TIMEOUT_EN to also exercise the bus timeout.
module tb_stage_memory;
    import stage_memory_pkg::*;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 256;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_clear;
    logic        mem_reg_write;
    logic        mem_mem_write;
    logic [1:0]  mem_result_src;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_write_data;
    logic [31:0] mem_pc_plus_4;
    logic [31:0] mem_imm_ext;
    logic [4:0]  mem_rd;
    logic        mem_stall;
    logic        bus_error;
    logic        wb_reg_write;
    logic [1:0]  wb_result_src;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_read_data;
    logic [31:0] wb_pc_plus_4;
    logic [31:0] wb_imm_ext;
    logic [4:0]  wb_rd;

    stage_memory_if #(.ADDR_W(32)) dmem ();

    stage_memory #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_clear       (wb_clear),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_write  (mem_mem_write),
        .mem_result_src (mem_result_src),
        .mem_alu_result (mem_alu_result),
        .mem_write_data (mem_write_data),
        .mem_pc_plus_4  (mem_pc_plus_4),
        .mem_imm_ext    (mem_imm_ext),
        .mem_rd         (mem_rd),
        .dmem           (dmem),
        .mem_stall      (mem_stall),
        .bus_error      (bus_error),
        .wb_reg_write   (wb_reg_write),
        .wb_result_src  (wb_result_src),
        .wb_alu_result  (wb_alu_result),
        .wb_read_data   (wb_read_data),
        .wb_pc_plus_4   (wb_pc_plus_4),
        .wb_imm_ext     (wb_imm_ext),
        .wb_rd          (wb_rd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [4:0]  rd;
    } wb_t;

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    endtask

    task automatic drive(input logic rw, input logic mw, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                         input logic [31:0] imm, input logic [4:0] rd);
        mem_reg_write  = rw;
        mem_mem_write  = mw;
        mem_result_src = src;
        mem_alu_result = alu;
        mem_write_data = wd;
        mem_pc_plus_4  = pc4;
        mem_imm_ext    = imm;
        mem_rd         = rd;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic push_exp(input logic [1:0] src, input logic [31:0] alu, input logic [31:0] rdata,
                            input logic [31:0] pc4, input logic [31:0] imm, input logic [4:0] rd);
        wb_t e;
        e.src = src; e.alu = alu; e.rdata = rdata; e.pc4 = pc4; e.imm = imm; e.rd = rd;
        exp_q.push_back(e);
    endtask

    // Acts as the memory slave for one access already on mem_*; returns just after the edge
    // that retires it into MEM/WB.
    task automatic do_access(input int ack_after, input logic [31:0] rdata, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic clr,
                             input int exp_stalls);
        int stalls;
        int busy;
        bit acked;
        stalls = 0;
        busy   = 0;
        acked  = 0;
        for (int c = 0; c < 40 && !acked; c++) begin
            @(negedge clk);
            if (mem_stall) stalls++;
            if (dmem.req) begin
                busy++;
                check("busy_we", 32'(dmem.we), 32'(we));
                check("busy_addr", dmem.addr, addr);
                check("busy_wdata", dmem.wdata, wdata);
                check("busy_bubble", 32'({wb_reg_write, wb_rd}), 32'h0);
                wb_clear = clr;
                if (busy == ack_after + 1) begin
                    dmem.ack   = 1'b1;
                    dmem.rdata = rdata;
                    wb_clear   = 1'b0;
                    acked      = 1'b1;
                end
            end
        end
        if (!acked) begin
            n_checks++;
            $display("FAIL access_ack: no ack issued within 40 cycles, busy=%0d", busy);
            wb_clear = 1'b0;
        end
        @(posedge clk);
        #1;
        dmem.ack   = 1'b0;
        dmem.rdata = 32'h0;
        @(negedge clk);
        if (mem_stall) stalls++;
        check("resp_req_low", 32'(dmem.req), 32'h0);
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        @(posedge clk);
        #1;
    endtask

    // Monitor: every retired register write must match the head of the scoreboard.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && wb_reg_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL wb_unexpected: got rd=%0d alu=0x%08h, want no writeback",
                             wb_rd, wb_alu_result);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_result_src", 32'(wb_result_src), 32'(e.src));
                    check("wb_alu_result", wb_alu_result, e.alu);
                    check("wb_read_data", wb_read_data, e.rdata);
                    check("wb_pc_plus_4", wb_pc_plus_4, e.pc4);
                    check("wb_imm_ext", wb_imm_ext, e.imm);
                    check("wb_rd", 32'(wb_rd), 32'(e.rd));
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        wb_clear   = 1'b0;
        dmem.ack   = 1'b0;
        dmem.rdata = 32'h0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(dmem.req), 32'h0);
        check("rst_we", 32'(dmem.we), 32'h0);
        check("rst_addr", dmem.addr, 32'h0);
        check("rst_wdata", dmem.wdata, 32'h0);
        check("rst_stall", 32'(mem_stall), 32'h0);
        check("rst_bus_error", 32'(bus_error), 32'h0);
        check("rst_wb", 32'({wb_reg_write, wb_result_src, wb_rd}), 32'h0);
        check("rst_wb_data", wb_alu_result | wb_read_data | wb_pc_plus_4 | wb_imm_ext, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Non-access instructions retire in one cycle with no stall.
        drive(1'b1, 1'b0, RESULT_SRC_ALU, 32'h0000_1234, 32'h0, 32'h104, 32'h55, 5'd5);
        push_exp(RESULT_SRC_ALU, 32'h0000_1234, 32'h0, 32'h104, 32'h55, 5'd5);
        @(negedge clk);
        check("alu_stall", 32'(mem_stall), 32'h0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, RESULT_SRC_PC4, 32'h0000_0008, 32'h0, 32'h200, 32'h0, 5'd6);
        push_exp(RESULT_SRC_PC4, 32'h0000_0008, 32'h0, 32'h200, 32'h0, 5'd6);
        @(negedge clk);
        check("pc4_stall", 32'(mem_stall), 32'h0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, RESULT_SRC_IMM, 32'h0, 32'h0, 32'h204, 32'hFFFF_F000, 5'd7);
        push_exp(RESULT_SRC_IMM, 32'h0, 32'h0, 32'h204, 32'hFFFF_F000, 5'd7);
        @(negedge clk);
        check("imm_stall", 32'(mem_stall), 32'h0);
        @(posedge clk);
        #1;

        // Load with ack on the 4th BUSY cycle: 1 IDLE + 4 BUSY stall cycles.
        drive(1'b1, 1'b0, RESULT_SRC_LOAD, 32'h40, 32'h0, 32'h108, 32'h0, 5'd9);
        push_exp(RESULT_SRC_LOAD, 32'h40, 32'hDEAD_BEEF, 32'h108, 32'h0, 5'd9);
        do_access(3, 32'hDEAD_BEEF, 1'b0, 32'h40, 32'h0, 1'b0, 5);

        // Store then load to the same address; wb_clear during the store's BUSY is harmless.
        drive(1'b0, 1'b1, RESULT_SRC_ALU, 32'h80, 32'hA5A5_A5A5, 32'h10C, 32'h0, 5'd0);
        do_access(1, 32'h1111_1111, 1'b1, 32'h80, 32'hA5A5_A5A5, 1'b1, 3);
        drive(1'b1, 1'b0, RESULT_SRC_LOAD, 32'h80, 32'h0, 32'h110, 32'h0, 5'd10);
        push_exp(RESULT_SRC_LOAD, 32'h80, 32'hA5A5_A5A5, 32'h110, 32'h0, 5'd10);
        do_access(0, 32'hA5A5_A5A5, 1'b0, 32'h80, 32'h0, 1'b0, 2);
        drive_idle();

        // Reset in the middle of a load; a late ack must be ignored.
        drive(1'b1, 1'b0, RESULT_SRC_LOAD, 32'h44, 32'h0, 32'h114, 32'h0, 5'd11);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(dmem.req), 32'h1);
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        check("midrst_req", 32'(dmem.req), 32'h0);
        check("midrst_stall", 32'(mem_stall), 32'h0);
        check("midrst_wb", 32'({wb_reg_write, wb_result_src, wb_rd}), 32'h0);
        check("midrst_wb_data", wb_alu_result | wb_read_data | wb_pc_plus_4 | wb_imm_ext, 32'h0);
        rst        = 1'b0;
        dmem.ack   = 1'b1;
        dmem.rdata = 32'h0000_0BAD;
        @(negedge clk);
        dmem.ack   = 1'b0;
        dmem.rdata = 32'h0;
        check("late_ack_req", 32'(dmem.req), 32'h0);
        check("late_ack_stall", 32'(mem_stall), 32'h0);
        check("late_ack_wb", 32'(wb_reg_write), 32'h0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, RESULT_SRC_ALU, 32'h0000_0777, 32'h0, 32'h118, 32'h0, 5'd12);
        push_exp(RESULT_SRC_ALU, 32'h0000_0777, 32'h0, 32'h118, 32'h0, 5'd12);
        @(negedge clk);
        check("post_rst_idle_stall", 32'(mem_stall), 32'h0);
        @(posedge clk);
        #1;

        // wb_clear on a non-access instruction bubbles MEM/WB.
        drive(1'b1, 1'b0, RESULT_SRC_ALU, 32'h0000_0999, 32'h0, 32'h11C, 32'h0, 5'd13);
        wb_clear = 1'b1;
        @(posedge clk);
        #1;
        wb_clear = 1'b0;
        drive_idle();
        @(negedge clk);
        check("clear_reg_write", 32'(wb_reg_write), 32'h0);
        check("clear_rd", 32'(wb_rd), 32'h0);
        @(posedge clk);
        #1;

`ifdef MEM_BUS_TIMEOUT_EN
        begin
            int  busy;
            bit  seen;
            bit  done;
            busy = 0;
            seen = 0;
            done = 0;
            drive(1'b1, 1'b0, RESULT_SRC_LOAD, 32'h84, 32'h0, 32'h120, 32'h0, 5'd14);
            push_exp(RESULT_SRC_LOAD, 32'h84, 32'h0, 32'h120, 32'h0, 5'd14);
            for (int c = 0; c < 40 && !done; c++) begin
                @(negedge clk);
                if (dmem.req) begin
                    busy++;
                    seen = 1'b1;
                end else if (seen) begin
                    done = 1'b1;
                end
            end
            check("tmo_busy_cycles", 32'(busy), 32'd4);
            check("tmo_bus_error", 32'(bus_error), 32'h1);
            check("tmo_resp_stall", 32'(mem_stall), 32'h0);
            @(posedge clk);
            #1;
            drive(1'b1, 1'b0, RESULT_SRC_LOAD, 32'h88, 32'h0, 32'h124, 32'h0, 5'd15);
            push_exp(RESULT_SRC_LOAD, 32'h88, 32'h0BAD_F00D, 32'h124, 32'h0, 5'd15);
            do_access(1, 32'h0BAD_F00D, 1'b0, 32'h88, 32'h0, 1'b0, 3);
            drive_idle();
            @(negedge clk);
            check("tmo_error_sticky", 32'(bus_error), 32'h1);
        end
`else
        @(negedge clk);
        check("bus_error_tied_low", 32'(bus_error), 32'h0);
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
